pattern_writer: RTL and testbench
=================================

# pattern_writer

Avalon-MM write master that fills a contiguous SDRAM buffer with a deterministic 64-bit test pattern and raises a one-cycle interrupt when the last word is accepted. It sits directly upstream of the checksum read master: software programs a start address, a seed and a word count, waits for the interrupt, then points the checksum master at the same buffer. The expected checksum is therefore computable on the host. A cycle counter over the fill is exposed for throughput measurement.

## Interface
Parameters:
- `ADDR_STEP`, default 8: byte increment of `master_address` per accepted word.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ctrl_write`  in  1  CSR write strobe.
- `ctrl_writedata`  in  32  CSR write data.
- `ctrl_read`  in  1  CSR read strobe.
- `ctrl_readdata`  out  32  CSR read data, registered.
- `ctrl_address`  in  2  CSR word address.
- `ctrl_waitrequest`  out  1  constant 0 once out of reset.
- `master_write`  out  1  write request.
- `master_writedata`  out  64  write data.
- `master_address`  out  32  byte address.
- `master_waitrequest`  in  1  slave stall.
- `master_burstcount`  out  1  tied 1.
- `master_byteenable`  out  8  tied 8'hFF.
- `irq`  out  1  one-cycle completion pulse.

## Operation
- CSR map, writes:
  - 0: `start_address`.
  - 1: `word_count`; this write also starts a run.
  - 2: `seed`.
  - 3: ignored.
- CSR map, reads:
  - 0: `start_address`.
  - 1: `word_count` as last written.
  - 2: status {30'b0, done, busy}.
  - 3: `elapsed`.
- FSM states are IDLE, RUN and DONE.
- IDLE/DONE, write to addr 1 with N ≠ 0:
  - load `remaining` = N, `master_address` = `start_address`, word index k = 0.
  - clear `elapsed` and done; go to RUN.
- IDLE/DONE, write to addr 1 with N = 0: go to DONE, pulse `irq`, `elapsed` = 0, no bus traffic.
- RUN behaviour:
  - `master_write` = 1.
  - `master_writedata` = {seed + 2k + 1, seed + 2k}; each 32-bit lane wraps mod 2^32.
  - A word is accepted on a cycle with `master_write` & ~`master_waitrequest`.
  - On acceptance: k += 1, `master_address` += `ADDR_STEP` (wraps mod 2^32), `remaining` -= 1.
  - Acceptance with `remaining` = 1 goes to DONE.
- While busy, writes to addresses 0 and 2 update the registers but do not affect the current run. Writes to address 1 are ignored; there is no abort.
- `elapsed` increments every cycle in RUN and saturates at 32'hFFFF_FFFF. It holds its value in DONE/IDLE.
- Status bits:
  - busy = 1 in RUN.
  - done is set on entry to DONE and cleared by the next start.
- `ctrl_readdata` is updated every cycle from `ctrl_address`, whether or not `ctrl_read` is asserted.

## Timing
- Reset (`reset_n` low, async) forces:
  - IDLE state.
  - `master_write` = 0, `master_address` = 0, `master_writedata` = 0.
  - `irq` = 0, `ctrl_readdata` = 0, `ctrl_waitrequest` = 0.
  - `start_address` = 0, `seed` = 0, `word_count` = 0, `elapsed` = 0, done = 0.
- Reset mid-run drops `master_write` immediately. The run is lost; no `irq`.
- Start write in cycle T: `master_write` = 1 in T+1 with word 0 and `start_address`.
- Under `master_waitrequest`, `master_write`, `master_address` and `master_writedata` hold stable until accepted.
- Zero-wait slave: one word per cycle, N words in cycles T+1..T+N, `elapsed` = N.
- Last acceptance in cycle L:
  - `master_write` = 0 from L+1.
  - `irq` = 1 in L+1 only.
  - status done readable from L+1.
- N = 0 start in cycle T: `irq` = 1 in T+1.
- CSR read latency is 1 cycle: `ctrl_readdata` is valid in the cycle after `ctrl_address` is presented.

## Test plan
- Reset values: assert `reset_n` = 0 mid-simulation → all outputs at reset values on the same edge; `master_write` = 0 and no `irq` afterwards.
- Basic fill, zero-wait slave, `start_address` = 0x1000_0000, seed = 0, N = 4:
  - writes to 0x1000_0000, 0x1000_0008, 0x1000_0010, 0x1000_0018.
  - data 0x00000001_00000000, 0x00000003_00000002, 0x00000005_00000004, 0x00000007_00000006.
  - `irq` pulses once the cycle after the 4th write; `elapsed` = 4; status = 0x2.
- Backpressure: `master_waitrequest` high on alternate cycles, N = 8 → 8 distinct addresses, each held stable while stalled; `elapsed` = 16; one `irq`.
- Wrap: seed = 0xFFFF_FFFE, N = 2 → data 0xFFFFFFFF_FFFFFFFE then 0x00000001_00000000. Separately, `start_address` = 0xFFFF_FFF8, N = 2 → address 0xFFFF_FFF8 then 0x0000_0000.
- N = 0 → no `master_write`; `irq` one cycle after the CSR write; `elapsed` = 0; status = 0x2.
- Start while busy: second write to addr 1 with N = 100 during an N = 10 run → exactly 10 words, one `irq`; addr 1 reads 10.

Source files
------------

// File: rtl/pattern_writer.sv
// Avalon-MM write master that fills a buffer with a seeded counting pattern.
// Raises a one-cycle irq when the last word is accepted.
module pattern_writer #(
  parameter int unsigned ADDR_STEP = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ctrl_write,
  input  logic [31:0] ctrl_writedata,
  input  logic        ctrl_read,
  output logic [31:0] ctrl_readdata,
  input  logic [1:0]  ctrl_address,
  output logic        ctrl_waitrequest,
  output logic        master_write,
  output logic [63:0] master_writedata,
  output logic [31:0] master_address,
  input  logic        master_waitrequest,
  output logic        master_burstcount,
  output logic [7:0]  master_byteenable,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [31:0] start_address;
  logic [31:0] word_count;
  logic [31:0] seed;
  logic [31:0] elapsed;
  logic [31:0] remaining;
  logic        done;

  logic start;
  logic zero;
  logic accept;
  logic last;
  logic finish;
  logic ctrl_read_unused;

  assign ctrl_read_unused  = ctrl_read;
  assign ctrl_waitrequest  = 1'b0;
  assign master_burstcount = 1'b1;
  assign master_byteenable = 8'hFF;

  assign master_write = (state == RUN);
  assign start  = ctrl_write && (ctrl_address == 2'd1) && (state != RUN);
  assign zero   = start && (ctrl_writedata == 32'd0);
  assign accept = master_write && !master_waitrequest;
  assign last   = accept && (remaining == 32'd1);
  assign finish = last || zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: if (start) state_n = zero ? DONE : RUN;
      RUN:        if (last)  state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_address <= '0;
      word_count    <= '0;
      seed          <= '0;
    end else if (ctrl_write) begin
      unique case (ctrl_address)
        2'd0:    start_address <= ctrl_writedata;
        2'd1:    if (state != RUN) word_count <= ctrl_writedata;
        2'd2:    seed <= ctrl_writedata;
        default: ;
      endcase
    end
  end

  // Both data lanes step by 2 per accepted word so each holds seed+2k(+1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      master_address   <= '0;
      master_writedata <= '0;
      remaining        <= '0;
    end else if (start && !zero) begin
      master_address   <= start_address;
      master_writedata <= {seed + 32'd1, seed};
      remaining        <= ctrl_writedata;
    end else if (accept) begin
      master_address   <= master_address + 32'(ADDR_STEP);
      master_writedata <= {master_writedata[63:32] + 32'd2,
                           master_writedata[31:0] + 32'd2};
      remaining        <= remaining - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elapsed <= '0;
      done    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      irq <= finish;
      if (start)
        elapsed <= '0;
      else if (master_write && elapsed != 32'hFFFF_FFFF)
        elapsed <= elapsed + 32'd1;
      if (finish)     done <= 1'b1;
      else if (start) done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_readdata <= '0;
    end else begin
      unique case (ctrl_address)
        2'd0:    ctrl_readdata <= start_address;
        2'd1:    ctrl_readdata <= word_count;
        2'd2:    ctrl_readdata <= {30'd0, done, master_write};
        default: ctrl_readdata <= elapsed;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_writer.sv
// Scoreboard bench for pattern_writer: stimulus queues expected writes,
// a negedge monitor pops and checks each accepted word and irq pulse.
module tb_pattern_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_write = 1'b0;
  logic [31:0] ctrl_writedata = '0;
  logic        ctrl_read = 1'b0;
  logic [31:0] ctrl_readdata;
  logic [1:0]  ctrl_address = '0;
  logic        ctrl_waitrequest;
  logic        master_write;
  logic [63:0] master_writedata;
  logic [31:0] master_address;
  logic        master_waitrequest;
  logic        master_burstcount;
  logic [7:0]  master_byteenable;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int irq_seen = 0;
  logic zero_armed = 1'b0;
  logic bp_en = 1'b0;
  logic phase = 1'b0;
  logic [95:0] exp_q[$];

  pattern_writer #(.ADDR_STEP(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ctrl_write(ctrl_write),
    .ctrl_writedata(ctrl_writedata),
    .ctrl_read(ctrl_read),
    .ctrl_readdata(ctrl_readdata),
    .ctrl_address(ctrl_address),
    .ctrl_waitrequest(ctrl_waitrequest),
    .master_write(master_write),
    .master_writedata(master_writedata),
    .master_address(master_address),
    .master_waitrequest(master_waitrequest),
    .master_burstcount(master_burstcount),
    .master_byteenable(master_byteenable),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Stall the first cycle of every word, accept on the second.
  always @(posedge clk) phase <= master_write ? ~phase : 1'b0;
  assign master_waitrequest = bp_en && !phase;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    ctrl_write = 1'b1;
    ctrl_address = a;
    ctrl_writedata = d;
    if (a == 2'd1 && d == 32'd0) zero_armed = 1'b1;
    @(negedge clk);
    ctrl_write = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a, input string name,
                          input logic [31:0] exp);
    @(negedge clk);
    ctrl_read = 1'b1;
    ctrl_address = a;
    @(negedge clk);
    ctrl_read = 1'b0;
    check(name, {32'd0, ctrl_readdata}, {32'd0, exp});
  endtask

  task automatic push_run(input logic [31:0] sa, input logic [31:0] sd,
                          input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({sa + 32'(8 * k), sd + 32'(2 * k + 1),
                       sd + 32'(2 * k)});
  endtask

  task automatic wait_done(input int irq_target);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || irq_seen < irq_target) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d words left expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    check("irq_count", 64'(irq_seen), 64'(irq_target));
  endtask

  // Monitor: checks each accepted word, stall stability and irq timing.
  initial begin
    logic        last_prev;
    logic        stall_prev;
    logic [95:0] held;
    logic [95:0] e;
    last_prev  = 1'b0;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last_prev  = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (irq || last_prev)
          check("irq_pulse", {63'd0, irq}, {63'd0, last_prev | zero_armed});
        if (irq) begin
          irq_seen++;
          zero_armed = 1'b0;
        end
        if (stall_prev)
          check("stall_hold", {master_address, master_writedata} == held,
                64'd1);
        last_prev = 1'b0;
        if (master_write && !master_waitrequest) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", {32'd0, master_address}, 64'hX);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", {32'd0, master_address}, {32'd0, e[95:64]});
            check("wr_data", master_writedata, e[63:0]);
            last_prev = (exp_q.size() == 0);
          end
        end
        stall_prev = master_write && master_waitrequest;
        held = {master_address, master_writedata};
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_write", {63'd0, master_write}, 64'd0);
    check("rst_irq", {63'd0, irq}, 64'd0);
    check("rst_waitreq", {63'd0, ctrl_waitrequest}, 64'd0);
    check("rst_rdata", {32'd0, ctrl_readdata}, 64'd0);
    reset_n = 1'b1;
    csr_read(2'd2, "rst_status", 32'd0);
    check("byteenable", {56'd0, master_byteenable}, 64'hFF);
    check("burstcount", {63'd0, master_burstcount}, 64'd1);

    // Basic fill, hand-computed vectors.
    csr_write(2'd0, 32'h1000_0000);
    csr_write(2'd2, 32'd0);
    exp_q.push_back({32'h1000_0000, 64'h00000001_00000000});
    exp_q.push_back({32'h1000_0008, 64'h00000003_00000002});
    exp_q.push_back({32'h1000_0010, 64'h00000005_00000004});
    exp_q.push_back({32'h1000_0018, 64'h00000007_00000006});
    csr_write(2'd1, 32'd4);
    wait_done(1);
    csr_read(2'd3, "basic_elapsed", 32'd4);
    csr_read(2'd2, "basic_status", 32'h2);
    csr_read(2'd1, "basic_count", 32'd4);

    // Backpressure on alternate cycles.
    bp_en = 1'b1;
    csr_write(2'd0, 32'h0000_2000);
    push_run(32'h0000_2000, 32'd0, 8);
    csr_write(2'd1, 32'd8);
    wait_done(2);
    csr_read(2'd3, "bp_elapsed", 32'd16);
    bp_en = 1'b0;

    // Data lane wrap.
    csr_write(2'd0, 32'h0000_3000);
    csr_write(2'd2, 32'hFFFF_FFFE);
    exp_q.push_back({32'h0000_3000, 64'hFFFFFFFF_FFFFFFFE});
    exp_q.push_back({32'h0000_3008, 64'h00000001_00000000});
    csr_write(2'd1, 32'd2);
    wait_done(3);

    // Address wrap.
    csr_write(2'd0, 32'hFFFF_FFF8);
    csr_write(2'd2, 32'd0);
    exp_q.push_back({32'hFFFF_FFF8, 64'h00000001_00000000});
    exp_q.push_back({32'h0000_0000, 64'h00000003_00000002});
    csr_write(2'd1, 32'd2);
    wait_done(4);

    // Zero-length run: irq in the cycle after the write.
    csr_write(2'd1, 32'd0);
    check("zero_irq", {63'd0, irq}, 64'd1);
    check("zero_nowrite", {63'd0, master_write}, 64'd0);
    wait_done(5);
    csr_read(2'd3, "zero_elapsed", 32'd0);
    csr_read(2'd2, "zero_status", 32'h2);

    // Start while busy is ignored; CSR updates do not disturb the run.
    csr_write(2'd0, 32'h0000_4000);
    csr_write(2'd2, 32'd5);
    push_run(32'h0000_4000, 32'd5, 10);
    csr_write(2'd1, 32'd10);
    csr_read(2'd2, "busy_status", 32'h1);
    csr_write(2'd0, 32'h0000_9000);
    csr_write(2'd1, 32'd100);
    wait_done(6);
    csr_read(2'd1, "busy_count", 32'd10);
    csr_read(2'd0, "busy_saddr", 32'h0000_9000);

    // Reset mid-run.
    csr_write(2'd0, 32'h0000_5000);
    push_run(32'h0000_5000, 32'd5, 10);
    csr_write(2'd1, 32'd10);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_write", {63'd0, master_write}, 64'd0);
    check("mid_rst_addr", {32'd0, master_address}, 64'd0);
    check("mid_rst_data", master_writedata, 64'd0);
    check("mid_rst_irq", {63'd0, irq}, 64'd0);
    check("mid_rst_rdata", {32'd0, ctrl_readdata}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_write", {63'd0, master_write}, 64'd0);
    check("post_rst_irq", 64'(irq_seen), 64'd6);
    csr_read(2'd2, "post_rst_status", 32'd0);
    csr_read(2'd0, "post_rst_saddr", 32'd0);
    csr_read(2'd1, "post_rst_count", 32'd0);
    csr_read(2'd3, "post_rst_elapsed", 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
